// File: rtl/multicycle_contr_if.sv
// ==========================================================================
// multicycle_contr_if : instruction-register / datapath side bundle of the
//                       multicycle MIPS control unit.        Rev 1.0
// ==========================================================================
`default_nettype none

interface multicycle_contr_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op_c;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_next_c;
  logic             reg_we;
  logic [1:0]       dest_reg_c;
  logic [1:0]       wd_c;
  logic             argA_c;
  logic [1:0]       argB_c;
  logic [3:0]       alu_c;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;
  logic [3:0]       state;

  // Controller side
  modport master (
    input  op_c, funct, zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_next_c, reg_we,
           dest_reg_c, wd_c, argA_c, argB_c, alu_c, illegal, instr_cnt, state
  );

  // Datapath / instruction-register side
  modport slave (
    output op_c, funct, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_next_c, reg_we,
           dest_reg_c, wd_c, argA_c, argB_c, alu_c, illegal, instr_cnt, state
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_contr.sv
// ==========================================================================
// multicycle_contr : Moore FSM sequencing one MIPS instruction over 3-5
//                    cycles with memory handshake and retire counter. Rev 1.0
// ==========================================================================
`default_nettype none

module multicycle_contr #(
  parameter int CNT_W  = 32,
  parameter bit JAL_EN = 1'b1,
  parameter bit JR_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_contr_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_FN_JR    = 6'b001000;

  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;
  localparam logic [3:0] c_ALU_SLT = 4'b0111;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  state_t     w_dec_next;
  logic       w_dec_ill;
  logic       w_fn_ok;
  logic [3:0] w_fn_alu;
  logic       w_retire;

  logic       w_mem_req, w_mem_we, w_iord, w_ir_we, w_pc_we, w_reg_we;
  logic       w_argA, w_ill;
  logic [1:0] w_pc_next, w_dest, w_wd, w_argB;
  logic [3:0] w_alu;

  always_comb begin
    w_dec_next = S_FETCH;
    w_dec_ill  = 1'b0;
    case (bus.op_c)
      c_OP_LW, c_OP_SW:   w_dec_next = S_MEMADR;
      c_OP_RTYPE:         w_dec_next = (JR_EN && bus.funct == c_FN_JR) ? S_JR : S_EXEC;
      c_OP_BEQ, c_OP_BNE: w_dec_next = S_BRANCH;
      c_OP_ADDI:          w_dec_next = S_ADDIEX;
      c_OP_J:             w_dec_next = S_JUMP;
      c_OP_JAL: begin
        if (JAL_EN) w_dec_next = S_JAL;
        else        w_dec_ill  = 1'b1;
      end
      default:            w_dec_ill  = 1'b1;
    endcase
  end

  // funct decode is reused in ALUWB, relying on funct being held stable
  always_comb begin
    w_fn_ok  = 1'b1;
    w_fn_alu = c_ALU_ADD;
    case (bus.funct)
      6'b100000: w_fn_alu = c_ALU_ADD;
      6'b100010: w_fn_alu = c_ALU_SUB;
      6'b100100: w_fn_alu = c_ALU_AND;
      6'b100101: w_fn_alu = c_ALU_OR;
      6'b101010: w_fn_alu = c_ALU_SLT;
      default:   w_fn_ok  = 1'b0;
    endcase
  end

  always_comb begin
    case (r_state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB,
      S_JUMP, S_JAL, S_JR: w_retire = 1'b1;
      S_MEMWR:             w_retire = bus.mem_ready;
      default:             w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: r_state <= w_dec_next;
        S_MEMADR: r_state <= (bus.op_c == c_OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (bus.mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= w_fn_ok ? S_ALUWB : S_FETCH;
        S_ADDIEX: r_state <= S_ADDIWB;
        default:  r_state <= S_FETCH;
      endcase
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_iord    = 1'b0;
    w_ir_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_pc_next = 2'b00;
    w_reg_we  = 1'b0;
    w_dest    = 2'b00;
    w_wd      = 2'b00;
    w_argA    = 1'b0;
    w_argB    = 2'b00;
    w_alu     = c_ALU_ADD;
    w_ill     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_argB    = 2'b01;
        w_ir_we   = bus.mem_ready;
        w_pc_we   = bus.mem_ready;
      end
      S_DECODE: begin
        w_argB = 2'b11;
        w_ill  = w_dec_ill;
      end
      S_MEMADR: begin
        w_argA = 1'b1;
        w_argB = 2'b10;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEMWB: begin
        w_reg_we = 1'b1;
        w_wd     = 2'b01;
      end
      S_MEMWR: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_iord    = 1'b1;
      end
      S_EXEC: begin
        w_argA = 1'b1;
        w_alu  = w_fn_alu;
        w_ill  = ~w_fn_ok;
      end
      S_ALUWB: begin
        w_reg_we = 1'b1;
        w_dest   = 2'b01;
        w_alu    = w_fn_alu;
      end
      S_BRANCH: begin
        w_argA    = 1'b1;
        w_alu     = c_ALU_SUB;
        w_pc_next = 2'b01;
        w_pc_we   = (bus.op_c == c_OP_BNE) ? ~bus.zero : bus.zero;
      end
      S_ADDIEX: begin
        w_argA = 1'b1;
        w_argB = 2'b10;
      end
      S_ADDIWB: w_reg_we = 1'b1;
      S_JUMP: begin
        w_pc_we   = 1'b1;
        w_pc_next = 2'b10;
      end
      S_JAL: begin
        w_pc_we   = 1'b1;
        w_pc_next = 2'b10;
        w_reg_we  = 1'b1;
        w_dest    = 2'b10;
        w_wd      = 2'b10;
      end
      S_JR: begin
        w_pc_we   = 1'b1;
        w_pc_next = 2'b11;
      end
      default: w_argB = 2'b01;
    endcase
  end

  // Reset suppresses only the side-effecting strobes; selects show FETCH values
  assign bus.mem_req    = w_mem_req & ~rst;
  assign bus.ir_we      = w_ir_we & ~rst;
  assign bus.pc_we      = w_pc_we & ~rst;
  assign bus.mem_we     = w_mem_we;
  assign bus.iord       = w_iord;
  assign bus.pc_next_c  = w_pc_next;
  assign bus.reg_we     = w_reg_we;
  assign bus.dest_reg_c = w_dest;
  assign bus.wd_c       = w_wd;
  assign bus.argA_c     = w_argA;
  assign bus.argB_c     = w_argB;
  assign bus.alu_c      = w_alu;
  assign bus.illegal    = w_ill;
  assign bus.instr_cnt  = r_cnt;
  assign bus.state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_contr.sv
// ==========================================================================
// tb_multicycle_contr : directed scoreboard bench for multicycle_contr. Rev 1.0
// ==========================================================================
`default_nettype none

module tb_multicycle_contr;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] fn;
  logic       zero;
  logic       mr;
  logic       sel;

  int vectors;
  int miscompares;

  multicycle_contr_if #(.CNT_W(32)) if_a ();
  multicycle_contr_if #(.CNT_W(4))  if_b ();

  assign if_a.op_c = op;  assign if_a.funct = fn;
  assign if_a.zero = zero; assign if_a.mem_ready = mr;
  assign if_b.op_c = op;  assign if_b.funct = fn;
  assign if_b.zero = zero; assign if_b.mem_ready = mr;

  multicycle_contr #(.CNT_W(32), .JAL_EN(1'b1), .JR_EN(1'b1)) u_dut_a (
    .clk (clk), .rst (rst), .bus (if_a)
  );
  multicycle_contr #(.CNT_W(4), .JAL_EN(1'b0), .JR_EN(1'b0)) u_dut_b (
    .clk (clk), .rst (rst), .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  o_st;
  logic [19:0] o_ctl;
  logic [31:0] o_cnt;

  always_comb begin
    if (sel) begin
      o_st  = if_b.state;
      o_cnt = {28'd0, if_b.instr_cnt};
      o_ctl = {if_b.mem_req, if_b.mem_we, if_b.iord, if_b.ir_we, if_b.pc_we,
               if_b.pc_next_c, if_b.reg_we, if_b.dest_reg_c, if_b.wd_c,
               if_b.argA_c, if_b.argB_c, if_b.alu_c, if_b.illegal};
    end else begin
      o_st  = if_a.state;
      o_cnt = if_a.instr_cnt;
      o_ctl = {if_a.mem_req, if_a.mem_we, if_a.iord, if_a.ir_we, if_a.pc_we,
               if_a.pc_next_c, if_a.reg_we, if_a.dest_reg_c, if_a.wd_c,
               if_a.argA_c, if_a.argB_c, if_a.alu_c, if_a.illegal};
    end
  end

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [19:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  function automatic logic [19:0] cv(
    input logic req, input logic we, input logic iord, input logic irw,
    input logic pcw, input logic [1:0] pcn, input logic rw, input logic [1:0] dst,
    input logic [1:0] wd, input logic a, input logic [1:0] b,
    input logic [3:0] alu, input logic ill);
    return {req, we, iord, irw, pcw, pcn, rw, dst, wd, a, b, alu, ill};
  endfunction

  // Push the expectation, let the combinational outputs settle, pop and compare
  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic [19:0] ctl, input logic [31:0] cnt);
    exp_t e;
    exp_t g;
    e.tag = tag; e.st = st; e.ctl = ctl; e.cnt = cnt;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    vectors++;
    assert (o_st === g.st) else begin
      miscompares++;
      $error("FAIL %s state: got %0d expected %0d", g.tag, o_st, g.st);
    end
    vectors++;
    assert (o_ctl === g.ctl) else begin
      miscompares++;
      $error("FAIL %s ctl: got %05h expected %05h", g.tag, o_ctl, g.ctl);
    end
    vectors++;
    assert (o_cnt === g.cnt) else begin
      miscompares++;
      $error("FAIL %s instr_cnt: got %0d expected %0d", g.tag, o_cnt, g.cnt);
    end
    @(negedge clk);
  endtask

  logic [19:0] E_RST, E_FW, E_FG, E_DEC, E_DILL, E_MADR, E_MRD, E_MWB, E_MWR;
  logic [19:0] E_EXSLT, E_WBSLT, E_EXILL, E_BRT, E_BRF, E_ADEX, E_ADWB;
  logic [19:0] E_J, E_JAL, E_JR;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; op = 6'd0; fn = 6'd0; zero = 1'b0; mr = 1'b1; sel = 1'b0;

    E_RST   = cv(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd1,4'b0010,0);
    E_FW    = cv(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd1,4'b0010,0);
    E_FG    = cv(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,4'b0010,0);
    E_DEC   = cv(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,4'b0010,0);
    E_DILL  = cv(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,4'b0010,1);
    E_MADR  = cv(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,4'b0010,0);
    E_MRD   = cv(1,0,1,0,0,2'd0,0,2'd0,2'd0,0,2'd0,4'b0010,0);
    E_MWB   = cv(0,0,0,0,0,2'd0,1,2'd0,2'd1,0,2'd0,4'b0010,0);
    E_MWR   = cv(1,1,1,0,0,2'd0,0,2'd0,2'd0,0,2'd0,4'b0010,0);
    E_EXSLT = cv(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd0,4'b0111,0);
    E_WBSLT = cv(0,0,0,0,0,2'd0,1,2'd1,2'd0,0,2'd0,4'b0111,0);
    E_EXILL = cv(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd0,4'b0010,1);
    E_BRT   = cv(0,0,0,0,1,2'd1,0,2'd0,2'd0,1,2'd0,4'b0110,0);
    E_BRF   = cv(0,0,0,0,0,2'd1,0,2'd0,2'd0,1,2'd0,4'b0110,0);
    E_ADEX  = cv(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,4'b0010,0);
    E_ADWB  = cv(0,0,0,0,0,2'd0,1,2'd0,2'd0,0,2'd0,4'b0010,0);
    E_J     = cv(0,0,0,0,1,2'd2,0,2'd0,2'd0,0,2'd0,4'b0010,0);
    E_JAL   = cv(0,0,0,0,1,2'd2,1,2'd2,2'd2,0,2'd0,4'b0010,0);
    E_JR    = cv(0,0,0,0,1,2'd3,0,2'd0,2'd0,0,2'd0,4'b0010,0);

    // Reset values, both instances
    cyc("rst_a", 4'd0, E_RST, 32'd0);
    sel = 1'b1;
    cyc("rst_b", 4'd0, E_RST, 32'd0);
    sel = 1'b0;

    // lw, ready tied high: 0,1,2,3,4,0
    rst = 1'b0; op = 6'b100011;
    cyc("lw_fetch",  4'd0, E_FG,   32'd0);
    cyc("lw_decode", 4'd1, E_DEC,  32'd0);
    cyc("lw_memadr", 4'd2, E_MADR, 32'd0);
    cyc("lw_memrd",  4'd3, E_MRD,  32'd0);
    cyc("lw_memwb",  4'd4, E_MWB,  32'd0);

    // sw with three wait cycles in MEMWR
    op = 6'b101011;
    cyc("sw_fetch",  4'd0, E_FG,   32'd1);
    cyc("sw_decode", 4'd1, E_DEC,  32'd1);
    cyc("sw_memadr", 4'd2, E_MADR, 32'd1);
    mr = 1'b0;
    cyc("sw_wait0",  4'd5, E_MWR,  32'd1);
    cyc("sw_wait1",  4'd5, E_MWR,  32'd1);
    cyc("sw_wait2",  4'd5, E_MWR,  32'd1);
    mr = 1'b1;
    cyc("sw_done",   4'd5, E_MWR,  32'd1);

    // beq / bne with zero=1
    op = 6'b000100; zero = 1'b1;
    cyc("beq_fetch",  4'd0, E_FG,  32'd2);
    cyc("beq_decode", 4'd1, E_DEC, 32'd2);
    cyc("beq_branch", 4'd8, E_BRT, 32'd2);
    op = 6'b000101;
    cyc("bne_fetch",  4'd0, E_FG,  32'd3);
    cyc("bne_decode", 4'd1, E_DEC, 32'd3);
    cyc("bne_branch", 4'd8, E_BRF, 32'd3);
    zero = 1'b0;

    // R-type slt, then an unsupported funct
    op = 6'b000000; fn = 6'b101010;
    cyc("slt_fetch",  4'd0, E_FG,    32'd4);
    cyc("slt_decode", 4'd1, E_DEC,   32'd4);
    cyc("slt_exec",   4'd6, E_EXSLT, 32'd4);
    cyc("slt_aluwb",  4'd7, E_WBSLT, 32'd4);
    fn = 6'b000000;
    cyc("badfn_fetch",  4'd0, E_FG,    32'd5);
    cyc("badfn_decode", 4'd1, E_DEC,   32'd5);
    cyc("badfn_exec",   4'd6, E_EXILL, 32'd5);

    // jal, jr, addi
    op = 6'b000011;
    cyc("jal_fetch",  4'd0,  E_FG,  32'd5);
    cyc("jal_decode", 4'd1,  E_DEC, 32'd5);
    cyc("jal_jal",    4'd12, E_JAL, 32'd5);
    op = 6'b000000; fn = 6'b001000;
    cyc("jr_fetch",  4'd0,  E_FG,  32'd6);
    cyc("jr_decode", 4'd1,  E_DEC, 32'd6);
    cyc("jr_jr",     4'd13, E_JR,  32'd6);
    op = 6'b001000;
    cyc("addi_fetch",  4'd0,  E_FG,   32'd7);
    cyc("addi_decode", 4'd1,  E_DEC,  32'd7);
    cyc("addi_ex",     4'd9,  E_ADEX, 32'd7);
    cyc("addi_wb",     4'd10, E_ADWB, 32'd7);

    // j with one fetch wait cycle
    op = 6'b000010; mr = 1'b0;
    cyc("j_fetchwait", 4'd0,  E_FW,  32'd8);
    mr = 1'b1;
    cyc("j_fetch",     4'd0,  E_FG,  32'd8);
    cyc("j_decode",    4'd1,  E_DEC, 32'd8);
    cyc("j_jump",      4'd11, E_J,   32'd8);

    // Unknown opcode drops in DECODE without retiring
    op = 6'b111111;
    cyc("badop_fetch",  4'd0, E_FG,   32'd9);
    cyc("badop_decode", 4'd1, E_DILL, 32'd9);

    // Reset in MEMRD takes effect before the next clock edge
    op = 6'b100011;
    cyc("lwr_fetch",  4'd0, E_FG,   32'd9);
    cyc("lwr_decode", 4'd1, E_DEC,  32'd9);
    cyc("lwr_memadr", 4'd2, E_MADR, 32'd9);
    mr = 1'b0;
    cyc("lwr_memrd",  4'd3, E_MRD,  32'd9);
    rst = 1'b1;
    cyc("lwr_async_rst", 4'd0, E_RST, 32'd0);

    // Reduced instance: jal and jr disabled, 4-bit counter
    sel = 1'b1; mr = 1'b1;
    cyc("b_rst", 4'd0, E_RST, 32'd0);
    rst = 1'b0; op = 6'b000011;
    cyc("b_jal_fetch",  4'd0, E_FG,   32'd0);
    cyc("b_jal_decode", 4'd1, E_DILL, 32'd0);
    op = 6'b000000; fn = 6'b001000;
    cyc("b_jr_fetch",  4'd0, E_FG,    32'd0);
    cyc("b_jr_decode", 4'd1, E_DEC,   32'd0);
    cyc("b_jr_exec",   4'd6, E_EXILL, 32'd0);
    op = 6'b000010;
    for (int k = 0; k < 17; k++) begin
      cyc("b_wrap_fetch",  4'd0,  E_FG,  32'(k % 16));
      cyc("b_wrap_decode", 4'd1,  E_DEC, 32'(k % 16));
      cyc("b_wrap_jump",   4'd11, E_J,   32'(k % 16));
    end
    cyc("b_wrap_end", 4'd0, E_FG, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
